burst_mem_responder: RTL and testbench

//  Responder (memory) end of the 64-bit burst-memory interface driven by the line adaptor.

---
 rtl/bmem_pkg.sv | 16 +
 rtl/bmem_line_store.sv | 48 ++++
 rtl/burst_mem_responder.sv | 155 +++++++++++++++
 tb/tb_burst_mem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bmem_pkg.sv
// Shared widths and FSM state type for the 64-bit burst-memory responder.
package bmem_pkg;

  localparam int BEAT_W      = 64;
  localparam int BEATS       = 4;
  localparam int LINE_W      = BEAT_W * BEATS;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } bmem_state_t;

endpackage

// File: rtl/bmem_line_store.sv
// Line array for the burst responder: one 64-bit beat write port and a
// registered 64-bit beat read port, both addressed by line index and beat.
module bmem_line_store
  import bmem_pkg::*;
#(
  parameter int MEM_LINES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [$clog2(MEM_LINES)-1:0] wr_line,
  input  logic [1:0]                   wr_beat,
  input  logic [BEAT_W-1:0]            wdata,
  input  logic                         re,
  input  logic [$clog2(MEM_LINES)-1:0] rd_line,
  input  logic [1:0]                   rd_beat,
  output logic [BEAT_W-1:0]            rdata
);

  logic [BEATS-1:0][BEAT_W-1:0] mem_q [MEM_LINES];
  logic [BEAT_W-1:0]            rdata_q;
  logic [BEAT_W-1:0]            rdata_d;

  // NOTE: the array itself is never reset, so stored lines survive rst; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_line][wr_beat] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[rd_line][rd_beat];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Burst-memory responder: 256-bit lines served as 4 x 64-bit beats after LATENCY cycles.
// Optional protocol checker enabled by defining BMEM_PROTOCOL_CHECK_EN.
module burst_mem_responder
  import bmem_pkg::*;
#(
  parameter int MEM_LINES = 256,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_address,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic [63:0] bmem_rdata,
  output logic        bmem_resp,
  output logic        proto_err
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  bmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       beat_q, beat_d;
  logic [IDX_W-1:0] line_q, line_d;
  logic             is_wr_q, is_wr_d;
  logic             req;
  logic             store_we;
  logic             store_re;
  logic [1:0]       rd_beat;
  logic             addr_unused;

  assign req = bmem_read | bmem_write;

  // NOTE: every comb output gets a default up front so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    line_d  = line_q;
    is_wr_d = is_wr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          line_d  = bmem_address[OFFSET_BITS +: IDX_W];
          is_wr_d = bmem_write;
          cnt_d   = CNT_W'(LATENCY - 1);
          beat_d  = '0;
          state_d = (LATENCY == 1) ? BURST : WAIT;
        end
      end
      WAIT: begin
        // Leaving as the count reaches zero puts beat 0 exactly LATENCY cycles after accept.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = BURST;
        end
      end
      BURST: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'(BEATS - 1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    line_q  <= line_d;
    is_wr_q <= is_wr_d;
  end

  // Reads are issued one cycle ahead so the registered beat lines up with its resp cycle.
  assign store_we = (state_q == BURST) && is_wr_q && !rst;
  assign store_re = (state_d == BURST) && !is_wr_d;
  assign rd_beat  = (state_q == BURST) ? beat_q + 2'd1 : 2'd0;

  bmem_line_store #(
    .MEM_LINES (MEM_LINES)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .we      (store_we),
    .wr_line (line_q),
    .wr_beat (beat_q),
    .wdata   (bmem_wdata),
    .re      (store_re),
    .rd_line (line_d),
    .rd_beat (rd_beat),
    .rdata   (bmem_rdata)
  );

  assign bmem_resp   = (state_q == BURST);
  assign addr_unused = ^bmem_address;

`ifdef BMEM_PROTOCOL_CHECK_EN
  logic [31:0] addr_q, addr_d;
  logic        after_done_q;
  logic        proto_err_q, proto_err_d;
  logic        viol;
  logic        in_flight;

  assign in_flight = (state_q == WAIT) || (state_q == BURST);

  always_comb begin
    addr_d = addr_q;
    if (state_q == IDLE && req) begin
      addr_d = bmem_address;
    end
    viol = 1'b0;
    if (state_q == IDLE && bmem_read && bmem_write)                          viol = 1'b1;
    if (state_q == IDLE && req && bmem_address[OFFSET_BITS-1:0] != '0)       viol = 1'b1;
    if (in_flight && !req)                                                   viol = 1'b1;
    if (in_flight && bmem_address != addr_q)                                 viol = 1'b1;
    if (after_done_q && req)                                                 viol = 1'b1;
    proto_err_d = proto_err_q | viol;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q  <= 1'b0;
      after_done_q <= 1'b0;
      addr_q       <= '0;
    end else begin
      proto_err_q  <= proto_err_d;
      after_done_q <= (state_q == DONE);
      addr_q       <= addr_d;
      if (viol && !proto_err_q) begin
        $error("burst_mem_responder: protocol violation, state %0d addr %h", state_q, bmem_address);
      end
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: two instances (LATENCY 4 and 1) against a line-level model.
module tb_burst_mem_responder;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic [31:0] addr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata [2];
  logic        resp  [2];
  logic        perr  [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    burst_mem_responder #(
      .MEM_LINES (256),
      .LATENCY   ((g == 0) ? 4 : 1)
    ) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .bmem_address (addr[g]),
      .bmem_read    (rd[g]),
      .bmem_write   (wr[g]),
      .bmem_wdata   (wdata[g]),
      .bmem_rdata   (rdata[g]),
      .bmem_resp    (resp[g]),
      .proto_err    (perr[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Model: whole lines per instance, plus per-cycle expected resp / read beat keyed by instance and cycle.
  logic [255:0] model_mem [2][256];
  bit           exp_resp  [int];
  logic [63:0]  exp_rd    [int];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int key(input int i, input int c);
    return i * 100000 + c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        automatic int k = key(i, cyc);
        automatic bit e = exp_resp.exists(k);
        check($sformatf("resp[%0d]@%0d", i, cyc), 64'(resp[i]), 64'(e));
        if (e && exp_rd.exists(k))
          check($sformatf("rdata[%0d]@%0d", i, cyc), rdata[i], exp_rd[k]);
      end
    end
  end

  // One burst: accept at cycle acc; abort_at < 4 asserts rst once that many beats were seen.
  task automatic burst(input int i, input logic [31:0] a, input bit is_wr, input bit both,
                       input logic [63:0] wb [4], input int abort_at,
                       output logic [63:0] rb [4], output int acc, output int first);
    int line, seen, nbeat, nstore;
    bit fin;
    line = int'((a >> 5) % 256);
    for (int k = 0; k < 4; k++) rb[k] = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    acc      = cyc;
    addr[i]  = a;
    rd[i]    = !is_wr || both;
    wr[i]    = is_wr;
    wdata[i] = wb[0];
    nbeat    = (abort_at < 4) ? abort_at + 1 : 4;
    nstore   = (abort_at < 4) ? abort_at : 4;
    for (int k = 0; k < nbeat; k++) begin
      exp_resp[key(i, acc + lat_of(i) + k)] = 1'b1;
      if (!is_wr) exp_rd[key(i, acc + lat_of(i) + k)] = model_mem[i][line][64*k +: 64];
    end
    if (is_wr)
      for (int k = 0; k < nstore; k++) model_mem[i][line][64*k +: 64] = wb[k];
    seen  = 0;
    first = -1;
    fin   = 1'b0;
    for (int t = 0; t < 40 && !fin; t++) begin
      @(negedge clk);
      if (abort_at < 4 && seen == abort_at) begin
        wdata[i] = wb[seen];
        rst[i]   = 1'b1;
        @(negedge clk);
        rst[i] = 1'b0;
        rd[i]  = 1'b0;
        wr[i]  = 1'b0;
        check("after_rst_resp", 64'(resp[i]), 64'd0);
        check("after_rst_rdata", rdata[i], 64'd0);
        fin = 1'b1;
      end else if (seen == 4) begin
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        fin   = 1'b1;
      end else begin
        wdata[i] = wb[seen];
        if (resp[i]) begin
          if (first < 0) first = cyc;
          rb[seen] = rdata[i];
          seen++;
        end
      end
    end
    check("burst_completed", 64'(fin), 64'd1);
  endtask

  logic [63:0] A [4], B [4], C [4], D [4], E [4], F [4], Z [4], rb [4], rb2 [4];
  int acc, first, acc2, first2;
  logic exp_pe;

  initial begin
    A = '{64'hA000_0000_0000_00A0, 64'hA111_1111_1111_11A1, 64'hA222_2222_2222_22A2, 64'hA333_3333_3333_33A3};
    B = '{64'hB0B0_0001_0203_0405, 64'hB1B1_1011_1213_1415, 64'hB2B2_2021_2223_2425, 64'hB3B3_3031_3233_3435};
    C = '{64'hC0C0_C0C0_C0C0_C0C0, 64'hC1C1_C1C1_C1C1_C1C1, 64'hC2C2_C2C2_C2C2_C2C2, 64'hC3C3_C3C3_C3C3_C3C3};
    D = '{64'hD000_0000_DEAD_0000, 64'hD111_1111_DEAD_1111, 64'hD222_2222_DEAD_2222, 64'hD333_3333_DEAD_3333};
    E = '{64'hE0E1_E2E3_E4E5_E6E7, 64'hE8E9_EAEB_ECED_EEEF, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    F = '{64'hF00D_0000_0000_0001, 64'hF00D_0000_0000_0002, 64'hF00D_0000_0000_0003, 64'hF00D_0000_0000_0004};
    Z = '{64'd0, 64'd0, 64'd0, 64'd0};
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; addr[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; wdata[i] = '0;
      for (int l = 0; l < 256; l++) model_mem[i][l] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) rst[i] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_resp[%0d]", i), 64'(resp[i]), 64'd0);
      check($sformatf("reset_rdata[%0d]", i), rdata[i], 64'd0);
      check($sformatf("reset_proto_err[%0d]", i), 64'(perr[i]), 64'd0);
    end
    chk_en = 1'b1;

    // Write then read line 0x40, LATENCY 4.
    burst(0, 32'h40, 1'b1, 1'b0, A, 4, rb, acc, first);
    check("t1_write_latency", 64'(first - acc), 64'd4);
    burst(0, 32'h40, 1'b0, 1'b0, Z, 4, rb, acc, first);
    check("t1_read_latency", 64'(first - acc), 64'd4);
    for (int k = 0; k < 4; k++) check($sformatf("t1_beat%0d", k), rb[k], A[k]);

    // Never-written line reads as zero.
    burst(0, 32'h1000, 1'b0, 1'b0, Z, 4, rb, acc, first);
    for (int k = 0; k < 4; k++) check($sformatf("t2_beat%0d", k), rb[k], 64'd0);

    // Read and write together: the write wins.
    burst(0, 32'h80, 1'b1, 1'b1, B, 4, rb, acc, first);
`ifdef BMEM_PROTOCOL_CHECK_EN
    exp_pe = 1'b1;
`else
    exp_pe = 1'b0;
`endif
    check("t3_proto_err", 64'(perr[0]), 64'(exp_pe));
    burst(0, 32'h80, 1'b0, 1'b0, Z, 4, rb, acc, first);
    for (int k = 0; k < 4; k++) check($sformatf("t3_beat%0d", k), rb[k], B[k]);

    // Reset after beat 1 of a write over existing data.
    burst(0, 32'hC0, 1'b1, 1'b0, C, 4, rb, acc, first);
    burst(0, 32'hC0, 1'b1, 1'b0, D, 2, rb, acc, first);
    burst(0, 32'hC0, 1'b0, 1'b0, Z, 4, rb, acc, first);
    check("t4_beat0", rb[0], D[0]);
    check("t4_beat1", rb[1], D[1]);
    check("t4_beat2", rb[2], C[2]);
    check("t4_beat3", rb[3], C[3]);

    // Line 256 aliases line 0.
    burst(0, 32'h2000, 1'b1, 1'b0, E, 4, rb, acc, first);
    burst(0, 32'h0, 1'b0, 1'b0, Z, 4, rb, acc, first);
    for (int k = 0; k < 4; k++) check($sformatf("t5_beat%0d", k), rb[k], E[k]);

    // LATENCY 1, back-to-back reads.
    burst(1, 32'h40, 1'b1, 1'b0, F, 4, rb, acc, first);
    check("t6_write_latency", 64'(first - acc), 64'd1);
    burst(1, 32'h40, 1'b0, 1'b0, Z, 4, rb, acc, first);
    burst(1, 32'h40, 1'b0, 1'b0, Z, 4, rb2, acc2, first2);
    check("t6_read_latency", 64'(first - acc), 64'd1);
    check("t6_accept_gap", 64'(acc2 - acc), 64'd6);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t6_rd1_beat%0d", k), rb[k], F[k]);
      check($sformatf("t6_rd2_beat%0d", k), rb2[k], F[k]);
    end

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
